fetch_sequencer: RTL and testbench

Controller that sequences the instruction-fetch stage. It drives the fetch stage's PC write enable, PC source select, branch target, and IF/ID flush/freeze controls. It handshakes with a variable-latency instruction memory and arbitrates between branch redirects from EX, load-use stalls from the hazard unit, and memory wait states. It sits between the hazard/branch logic and the fetch stage, and also keeps fetch performance counters and a memory timeout flag.

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 tb/tb_fetch_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-control bundle between the fetch sequencer and the branch/hazard/imem/PC side.
// master: the sequencer; slave: the surrounding pipeline logic.
interface fetch_if #(
  parameter int unsigned CNT_W = 16
);
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             hazard_stall;
  logic             imem_ready;
  logic             imem_req;
  logic             PCWrite;
  logic             PCSrc;
  logic [31:0]      Branch_Address;
  logic             flush;
  logic             freeze;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] stall_count;
  logic             fetch_err;

  modport master (
    input  branch_taken, branch_target, hazard_stall, imem_ready,
    output imem_req, PCWrite, PCSrc, Branch_Address, flush, freeze,
           fetch_count, stall_count, fetch_err
  );

  modport slave (
    output branch_taken, branch_target, hazard_stall, imem_ready,
    input  imem_req, PCWrite, PCSrc, Branch_Address, flush, freeze,
           fetch_count, stall_count, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: arbitrates branch redirects, load-use stalls and imem wait states,
// and keeps saturating fetch/stall counters plus a sticky memory-timeout flag.
module fetch_sequencer #(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned CNT_W             = 16,
  parameter int unsigned TIMEOUT           = 64
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_W = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StHold, StFetch, StRedirPend} state_e;

  state_e            r_state, w_state_d;
  logic [3:0]        r_hold;
  logic [31:0]       r_target, w_target_d;
  logic [WAIT_W-1:0] r_wait, w_wait_d;
  logic [CNT_W-1:0]  r_fetch_cnt, r_stall_cnt;
  logic              r_err;

  logic        w_req, w_pcwrite, w_pcsrc, w_flush, w_freeze;
  logic [31:0] w_baddr;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StHold;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StHold:      if (r_hold <= 4'd1) w_state_d = StFetch;
      StFetch:     if (!bus.imem_ready && bus.branch_taken) w_state_d = StRedirPend;
      StRedirPend: if (bus.imem_ready) w_state_d = StFetch;
      default:     w_state_d = StHold;
    endcase
  end

  // Output logic
  always_comb begin
    w_req     = 1'b0;
    w_pcwrite = 1'b0;
    w_pcsrc   = 1'b0;
    w_baddr   = 32'd0;
    w_flush   = 1'b0;
    w_freeze  = 1'b0;
    unique case (r_state)
      StHold: w_flush = 1'b1;
      StFetch: begin
        w_req = 1'b1;
        if (bus.branch_taken) begin
          w_flush = 1'b1;
          if (bus.imem_ready) begin
            w_pcwrite = 1'b1;
            w_pcsrc   = 1'b1;
            w_baddr   = bus.branch_target;
          end
        end else if (bus.hazard_stall) begin
          w_freeze = 1'b1;
        end else if (bus.imem_ready) begin
          w_pcwrite = 1'b1;
        end else begin
          w_flush = 1'b1;
        end
      end
      StRedirPend: begin
        // Outstanding access completes here; its data is squashed by flush.
        w_req   = 1'b1;
        w_flush = 1'b1;
        w_baddr = (bus.branch_taken && bus.imem_ready) ? bus.branch_target : r_target;
        if (bus.imem_ready) begin
          w_pcwrite = 1'b1;
          w_pcsrc   = 1'b1;
        end
      end
      default: w_flush = 1'b1;
    endcase
  end

  always_comb begin
    w_target_d = r_target;
    if (bus.branch_taken &&
        ((r_state == StFetch && !bus.imem_ready) || r_state == StRedirPend)) begin
      w_target_d = bus.branch_target;
    end
  end

  always_comb begin
    w_wait_d = r_wait;
    if (bus.imem_ready) begin
      w_wait_d = '0;
    end else if (w_req && r_wait != TIMEOUT_W) begin
      w_wait_d = r_wait + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= 4'(RESET_HOLD_CYCLES);
      r_target    <= 32'd0;
      r_wait      <= '0;
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == StHold && r_hold != 4'd0) r_hold <= r_hold - 4'd1;
      r_target <= w_target_d;
      r_wait   <= w_wait_d;
      if (w_pcwrite && r_fetch_cnt != CNT_MAX) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (r_state == StFetch && !w_pcwrite && r_stall_cnt != CNT_MAX) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (TIMEOUT != 0 && w_wait_d == TIMEOUT_W) r_err <= 1'b1;
    end
  end

  assign bus.imem_req       = w_req;
  assign bus.PCWrite        = w_pcwrite;
  assign bus.PCSrc          = w_pcsrc;
  assign bus.Branch_Address = w_baddr;
  assign bus.flush          = w_flush;
  assign bus.freeze         = w_freeze;
  assign bus.fetch_count    = r_fetch_cnt;
  assign bus.stall_count    = r_stall_cnt;
  assign bus.fetch_err      = r_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares every output.
module tb_fetch_sequencer;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = 15;

  logic clk;
  logic rst;

  fetch_if #(.CNT_W(CW)) bus ();

  fetch_sequencer #(
    .RESET_HOLD_CYCLES(2),
    .CNT_W            (CW),
    .TIMEOUT          (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int          id;
    logic        req;
    logic        pcw;
    logic        pcs;
    logic [31:0] ba;
    logic        fl;
    logic        fr;
    logic        err;
    int          fc;
    int          sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;
  int   exp_fc = 0;
  int   exp_sc = 0;
  logic exp_err = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int id, input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", id, nm, got, want);
    end
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "imem_req",       32'(bus.imem_req),       32'(e.req));
      chk(e.id, "PCWrite",        32'(bus.PCWrite),        32'(e.pcw));
      chk(e.id, "PCSrc",          32'(bus.PCSrc),          32'(e.pcs));
      chk(e.id, "Branch_Address", bus.Branch_Address,      e.ba);
      chk(e.id, "flush",          32'(bus.flush),          32'(e.fl));
      chk(e.id, "freeze",         32'(bus.freeze),         32'(e.fr));
      chk(e.id, "fetch_err",      32'(bus.fetch_err),      32'(e.err));
      chk(e.id, "fetch_count",    32'(bus.fetch_count),    32'(e.fc));
      chk(e.id, "stall_count",    32'(bus.stall_count),    32'(e.sc));
    end
  end

  // One cycle: drive inputs just after the edge, push what the outputs must be this cycle.
  task automatic step(input bit r, input bit bt, input logic [31:0] tgt, input bit hs,
                      input bit rdy, input bit req, input bit pcw, input bit pcs,
                      input logic [31:0] ba, input bit fl, input bit fr, input bit in_fetch);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    bus.hazard_stall  = hs;
    bus.imem_ready    = rdy;
    if (!r) begin
      exp_fc  = 0;
      exp_sc  = 0;
      exp_err = 1'b0;
    end
    e.id  = vec_id;
    e.req = req; e.pcw = pcw; e.pcs = pcs; e.ba = ba; e.fl = fl; e.fr = fr;
    e.err = exp_err; e.fc = exp_fc; e.sc = exp_sc;
    q.push_back(e);
    vec_id++;
    if (r) begin
      if (pcw) exp_fc = (exp_fc == CMAX) ? CMAX : exp_fc + 1;
      else if (in_fetch) exp_sc = (exp_sc == CMAX) ? CMAX : exp_sc + 1;
    end
  endtask

  task automatic hold_cyc(input bit r);
    step(r, 1'b0, 32'h0, 1'b0, 1'b1, 0, 0, 0, 32'h0, 1, 0, 0);
  endtask

  task automatic normal(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 0, 0, 1);
  endtask

  initial begin
    rst               = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.hazard_stall  = 1'b0;
    bus.imem_ready    = 1'b1;

    // Reset state, then two HOLD cycles after release
    hold_cyc(0);
    hold_cyc(0);
    hold_cyc(1);
    hold_cyc(1);

    // Steady fetch: 12 cycles (fetch_count reads 10 on the 11th)
    normal(12);

    // Load-use stall for 3 cycles
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 1, 1, 1, 0, 0, 32'h0, 0, 1, 1);

    // Taken branch with memory ready, then sequential; fetch_count saturates at 15
    step(1, 1, 32'h40, 0, 1, 1, 1, 1, 32'h40, 1, 0, 1);
    normal(4);

    // Branch during wait -> REDIR_PEND, newer branch overrides, hazard ignored
    step(1, 1, 32'h80, 0, 0, 1, 0, 0, 32'h0,  1, 0, 1);
    step(1, 1, 32'hC0, 0, 0, 1, 0, 0, 32'h80, 1, 0, 0);
    step(1, 0, 32'h0,  1, 0, 1, 0, 0, 32'hC0, 1, 0, 0);
    step(1, 0, 32'h0,  0, 1, 1, 1, 1, 32'hC0, 1, 0, 0);
    normal(1);

    // Branch + ready in the same REDIR_PEND cycle uses the new target directly
    step(1, 1, 32'h200, 0, 0, 1, 0, 0, 32'h0,   1, 0, 1);
    step(1, 1, 32'h300, 0, 1, 1, 1, 1, 32'h300, 1, 0, 0);
    normal(1);

    // Memory timeout: flag sets after 4 unanswered cycles and stays set
    for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 1, 0, 1);
    exp_err = 1'b1;
    step(1, 0, 32'h0, 0, 0, 1, 0, 0, 32'h0, 1, 0, 1);
    normal(2);

    // Reset while REDIR_PEND: immediate reset outputs, redirect discarded
    step(1, 1, 32'h100, 0, 0, 1, 0, 0, 32'h0, 1, 0, 1);
    step(0, 0, 32'h0,   0, 1, 0, 0, 0, 32'h0, 1, 0, 0);
    hold_cyc(1);
    hold_cyc(1);
    normal(2);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
